// File: rtl/mem_stage.sv
// mem_stage: LoongArch pipeline memory stage that registers one EX instruction, extracts load data,
// selects the result and forwards it to WB and to the ID bypass network.
module mem_stage #(
    parameter int EXCEPT_LEN    = 82,
    parameter int ES2MS_BUS_LEN = 76 + EXCEPT_LEN,
    parameter int MS2WS_BUS_LEN = 70 + EXCEPT_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     es2ms_valid,
    output logic                     ms_allowin,
    input  logic [ES2MS_BUS_LEN-1:0] es2ms_bus,
    input  logic                     ws_allowin,
    output logic                     ms2ws_valid,
    output logic [MS2WS_BUS_LEN-1:0] ms2ws_bus,
    input  logic [31:0]              data_sram_rdata,
    input  logic                     wb_ex,
    input  logic                     ertn_flush,
    output logic [37:0]              ms_rf_zip,
    output logic                     ms_csr_re,
    output logic                     ms_ex_flag
);
    logic                     ms_valid_q, ms_valid_d;
    logic [ES2MS_BUS_LEN-1:0] payload_q, payload_d;
    logic                     ms_ready_go;
    logic                     flush;
    logic [31:0]              ms_pc;
    logic                     gr_we;
    logic [4:0]               dest;
    logic [31:0]              alu_result;
    logic                     res_from_mem;
    logic                     ld_b, ld_bu, ld_h, ld_hu, ld_w;
    logic [EXCEPT_LEN-1:0]    except_zip;
    logic [31:0]              rdata_sh;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic [31:0]              load_data;
    logic [31:0]              final_result;

    assign ms_ready_go = 1'b1;
    assign flush       = wb_ex | ertn_flush;
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid_q & ms_ready_go;

    always_comb begin
        ms_valid_d = flush ? 1'b0 : (ms_allowin ? es2ms_valid : ms_valid_q);
        payload_d  = (es2ms_valid & ms_allowin & ~flush) ? es2ms_bus : payload_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            payload_q  <= payload_d;
        end
    end

    assign {ms_pc, gr_we, dest, alu_result, res_from_mem,
            ld_b, ld_bu, ld_h, ld_hu, ld_w, except_zip} = payload_q;

    // Byte lane selected by the low address bits; halfword by addr[1] only.
    always_comb begin
        rdata_sh  = data_sram_rdata >> {alu_result[1:0], 3'b000};
        ld_byte   = rdata_sh[7:0];
        ld_half   = alu_result[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        load_data = ld_w  ? data_sram_rdata :
                    ld_b  ? {{24{ld_byte[7]}}, ld_byte} :
                    ld_bu ? {24'd0, ld_byte} :
                    ld_h  ? {{16{ld_half[15]}}, ld_half} :
                    ld_hu ? {16'd0, ld_half} : 32'd0;
        final_result = res_from_mem ? load_data : alu_result;
    end

    assign ms2ws_bus  = {ms_pc, gr_we, dest, final_result, except_zip};
    assign ms_rf_zip  = ms_valid_q ? {gr_we, dest, final_result} : 38'd0;
    assign ms_csr_re  = ms_valid_q & except_zip[1];
    assign ms_ex_flag = ms_valid_q & (except_zip[3] | except_zip[2]);
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline. Sits between the execute stage and the writeback stage.
- Registers one instruction from EX and takes the synchronous data-SRAM read word that returns in this cycle.
- Aligns, extracts and sign/zero-extends load data, then selects the final result.
- Forwards the result to the decode stage for bypass, and forwards the exception/CSR bundle to WB unchanged.

Parameters:
- EXCEPT_LEN, 82, width of the exception/CSR bundle. Layout MSB→LSB: {csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], wb_ex, ertn_flush, csr_re, csr_we}.
- ES2MS_BUS_LEN, 76+EXCEPT_LEN, EX→MEM bus width.
- MS2WS_BUS_LEN, 70+EXCEPT_LEN, MEM→WB bus width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- es2ms_valid  in  1  EX holds a valid instruction for MEM.
- ms_allowin  out  1  MEM can accept an instruction this cycle.
- es2ms_bus  in  ES2MS_BUS_LEN  {es_pc[31:0], gr_we, dest[4:0], alu_result[31:0], res_from_mem, ld_op[4:0]={ld_b,ld_bu,ld_h,ld_hu,ld_w}, except_zip}.
- ws_allowin  in  1  WB can accept an instruction.
- ms2ws_valid  out  1  MEM presents a valid instruction to WB.
- ms2ws_bus  out  MS2WS_BUS_LEN  {ms_pc[31:0], gr_we, dest[4:0], final_result[31:0], except_zip}.
- data_sram_rdata  in  32  read data for the access issued by EX in the previous cycle.
- wb_ex  in  1  exception commit from WB; flushes this stage.
- ertn_flush  in  1  ertn commit from WB; flushes this stage.
- ms_rf_zip  out  38  bypass bundle {ms_rf_we, ms_rf_waddr[4:0], ms_rf_wdata[31:0]} to ID.
- ms_csr_re  out  1  MEM holds a valid CSR-read instruction; ID must stall on a register match.
- ms_ex_flag  out  1  MEM holds a valid wb_ex or ertn instruction; EX must suppress store writes.

Behaviour:
- State: ms_valid plus a payload register of ES2MS_BUS_LEN bits.
- Reset: asynchronous. ms_valid=0 and payload=0 immediately, so every output derived from them is 0 during and after reset.
- ms_ready_go is constant 1; this stage adds no stall cycles.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_valid update priority at each clock edge:
  1. wb_ex | ertn_flush → 0 (the flush wins over a simultaneous accept);
  2. else, if ms_allowin → es2ms_valid.
- Payload capture: when es2ms_valid & ms_allowin & ~(wb_ex|ertn_flush). Otherwise the payload holds its value.
- ms2ws_valid = ms_valid & ms_ready_go. Latency from EX to WB is one cycle. The bus is stable while ms2ws_valid=1 and ws_allowin=0.
- Load extraction, addr = alu_result[1:0]:
  - ld_w: whole word; address misalignment is EX's responsibility.
  - ld_b / ld_bu: byte = rdata[8*addr +: 8], sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: half = addr[1] ? rdata[31:16] : rdata[15:0], sign- or zero-extended.
  - ld_op must be one-hot when res_from_mem=1. If none is set, the load result is 0.
- final_result = res_from_mem ? load_data : alu_result.
- ms_rf_zip fields:
  - we = ms_valid & gr_we;
  - waddr = dest;
  - wdata = final_result.
  - Bundle is all-zero when ms_valid=0.
- ms_csr_re = ms_valid & except_zip[1].
- ms_ex_flag = ms_valid & (except_zip[3] | except_zip[2]).
- except_zip passes through unmodified in the payload.
- Flush while ms_valid=1: the instruction dies and is never presented to WB after that edge.
- Back-pressure: with ws_allowin=0 and ms_valid=1, ms_allowin=0 and EX must hold its instruction.

Test Plan:
- Reset asserted mid-cycle while ms_valid=1 → ms2ws_valid and ms_rf_zip drop to 0 before the next clock edge; ms_allowin=1.
- ld_b at alu_result=0x1003, rdata=0x80FF_1234 → final_result=0xFFFF_FF80. ld_bu at the same address → 0x0000_0080.
- ld_h at alu_result=0x2002, rdata=0x8001_7FFF → 0xFFFF_8001. ld_hu at alu_result=0x2000 with the same rdata → 0x0000_7FFF.
- Non-load add with alu_result=0x1234_5678, gr_we=1, dest=5 → ms_rf_zip={1,5,0x1234_5678}. The next cycle WB sees ms2ws_valid=1 with the same pc.
- ws_allowin=0 for 3 cycles while es2ms_valid=1 → ms_allowin=0 and ms2ws_bus stays constant. On release the transfer completes in exactly 1 cycle.
- wb_ex=1 on the same edge that es2ms_valid=1 and ms_allowin=1 → ms_valid=0 next cycle and the payload is not updated. A syscall in MEM drives ms_ex_flag=1.
